// File: rtl/red_pitaya_asg_pkg.sv
// Shared types and constants for the ASG frequency-sweep controller.
package red_pitaya_asg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sweep_state_t;

  localparam logic [1:0] MODE_SINGLE   = 2'd0;
  localparam logic [1:0] MODE_REPEAT   = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;

  // Step words carry 16 fractional bits on top of the buffer address.
  function automatic int step_w(input int rsz);
    return rsz + 16;
  endfunction

endpackage

// File: rtl/red_pitaya_asg_sweep.sv
// Stepped frequency sweep feeding one ASG channel's phase-step word.
//
// state | meaning
// IDLE  | step_o held at its last value, waiting for start_i
// RUN   | dwelling on / advancing through sweep points
module red_pitaya_asg_sweep
  import red_pitaya_asg_pkg::*;
#(
  parameter int RSZ = 14
) (
  input  logic            dac_clk_i,
  input  logic            dac_rst_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [RSZ+15:0] set_start_i,
  input  logic [RSZ+15:0] set_stop_i,
  input  logic [RSZ+15:0] set_inc_i,
  input  logic [31:0]     set_dwell_i,
  input  logic [1:0]      set_mode_i,
  input  logic [15:0]     set_legs_i,
  output logic [RSZ+15:0] step_o,
  output logic            point_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int SW = step_w(RSZ);

  sweep_state_t  state;
  logic [SW-1:0] start_r;
  logic [SW-1:0] stop_r;
  logic [SW-1:0] inc_r;
  logic [SW-1:0] target;
  logic          dir_up;
  logic [31:0]   dwell_r;
  logic [31:0]   dwell_cnt;
  logic [1:0]    mode_r;
  logic [15:0]   leg_cnt;

  logic [SW:0]   sum_up;
  logic [SW:0]   dif_dn;
  logic [SW-1:0] next_step;
  logic          last_leg;

  // One extra bit catches overshoot past the top and underflow below zero.
  always_comb begin
    sum_up = {1'b0, step_o} + {1'b0, inc_r};
    dif_dn = {1'b0, step_o} - {1'b0, inc_r};
    if (dir_up) begin
      next_step = (sum_up >= {1'b0, target}) ? target : sum_up[SW-1:0];
    end else begin
      next_step = (dif_dn[SW] || (dif_dn[SW-1:0] <= target)) ? target : dif_dn[SW-1:0];
    end
    last_leg = (leg_cnt == 16'd1) || (mode_r == MODE_SINGLE) || (mode_r == 2'd3);
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state     <= IDLE;
      step_o    <= '0;
      point_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      start_r   <= '0;
      stop_r    <= '0;
      inc_r     <= '0;
      target    <= '0;
      dir_up    <= 1'b0;
      dwell_r   <= '0;
      dwell_cnt <= '0;
      mode_r    <= MODE_SINGLE;
      leg_cnt   <= '0;
    end else begin
      point_o <= 1'b0;
      done_o  <= 1'b0;
      if (abort_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else if (start_i) begin
        state     <= RUN;
        busy_o    <= 1'b1;
        point_o   <= 1'b1;
        step_o    <= set_start_i;
        start_r   <= set_start_i;
        stop_r    <= set_stop_i;
        target    <= set_stop_i;
        dir_up    <= (set_stop_i >= set_start_i);
        inc_r     <= set_inc_i;
        dwell_r   <= set_dwell_i;
        dwell_cnt <= set_dwell_i;
        mode_r    <= set_mode_i;
        leg_cnt   <= set_legs_i;
      end else if (state == RUN) begin
        if (dwell_cnt != 32'd0) begin
          dwell_cnt <= dwell_cnt - 32'd1;
        end else if (step_o != target) begin
          step_o    <= next_step;
          dwell_cnt <= dwell_r;
          point_o   <= 1'b1;
        end else if (last_leg) begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end else begin
          // Leg turnaround; a leg count of zero never runs out.
          if (leg_cnt != 16'd0) leg_cnt <= leg_cnt - 16'd1;
          dwell_cnt <= dwell_r;
          if (mode_r == MODE_REPEAT) begin
            step_o  <= start_r;
            point_o <= (start_r != step_o);
          end else begin
            target <= (target == stop_r) ? start_r : stop_r;
            dir_up <= ~dir_up;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_asg_sweep.sv
// Self-checking bench for red_pitaya_asg_sweep: table vectors, random sweeps, corner sequences.
module tb_red_pitaya_asg_sweep;

  localparam int RSZ = 14;
  localparam int SW  = RSZ + 16;

  logic          dac_clk_i = 1'b0;
  logic          dac_rst_i = 1'b1;
  logic          start_i   = 1'b0;
  logic          abort_i   = 1'b0;
  logic [SW-1:0] set_start_i = '0;
  logic [SW-1:0] set_stop_i  = '0;
  logic [SW-1:0] set_inc_i   = '0;
  logic [31:0]   set_dwell_i = '0;
  logic [1:0]    set_mode_i  = '0;
  logic [15:0]   set_legs_i  = '0;
  logic [SW-1:0] step_o;
  logic          point_o;
  logic          busy_o;
  logic          done_o;

  red_pitaya_asg_sweep #(.RSZ(RSZ)) dut (
    .dac_clk_i  (dac_clk_i),
    .dac_rst_i  (dac_rst_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .set_start_i(set_start_i),
    .set_stop_i (set_stop_i),
    .set_inc_i  (set_inc_i),
    .set_dwell_i(set_dwell_i),
    .set_mode_i (set_mode_i),
    .set_legs_i (set_legs_i),
    .step_o     (step_o),
    .point_o    (point_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 dac_clk_i = ~dac_clk_i;

  typedef struct packed {
    logic [SW-1:0] start;
    logic [SW-1:0] stop;
    logic [SW-1:0] inc;
    logic [31:0]   dwell;
    logic [1:0]    mode;
    logic [15:0]   legs;
  } cfg_t;

  typedef struct packed {
    cfg_t          c;
    int            exp_pts;
    int            exp_done;
    logic [SW-1:0] exp_final;
  } vec_t;

  typedef struct packed {
    logic [SW-1:0] step;
    logic          pt;
    logic          busy;
    logic          done;
  } obs_t;

  int   checks = 0;
  int   errors = 0;
  obs_t mdl[$];
  int   mdl_pts;
  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] toward(input logic [SW-1:0] p, input logic [SW-1:0] t,
                                           input logic [SW-1:0] inc);
    longint n;
    if (t > p) begin
      n = longint'(p) + longint'(inc);
      return (n >= longint'(t)) ? t : SW'(n);
    end else begin
      n = longint'(p) - longint'(inc);
      return (n <= longint'(t)) ? t : SW'(n);
    end
  endfunction

  task automatic add_point(input logic [SW-1:0] v, input bit pulse, input logic [31:0] dwell);
    for (int k = 0; k <= int'(dwell); k++) mdl.push_back('{v, (k == 0) && pulse, 1'b1, 1'b0});
    if (pulse) mdl_pts++;
  endtask

  // Expected per-clock outputs after the start edge, built from the list of points per leg.
  task automatic build_model(input cfg_t c);
    logic [SW-1:0] s, t, p, tmp;
    int nlegs;
    bit first;
    mdl.delete();
    mdl_pts = 0;
    nlegs = (c.mode == 2'd1 || c.mode == 2'd2) ? int'(c.legs) : 1;
    if (nlegs == 0) nlegs = 64;
    s = c.start;
    t = c.stop;
    p = s;
    for (int leg = 0; leg < nlegs; leg++) begin
      p = s;
      first = 1;
      for (int guard = 0; guard < 4096; guard++) begin
        add_point(p, first ? (leg == 0 || (c.mode == 2'd1 && s != t)) : 1'b1, c.dwell);
        if (p == t) break;
        p = toward(p, t, c.inc);
        first = 0;
      end
      if (c.mode == 2'd2) begin
        tmp = s; s = t; t = tmp;
      end
    end
    mdl.push_back('{p, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic set_cfg(input cfg_t c);
    set_start_i = c.start;
    set_stop_i  = c.stop;
    set_inc_i   = c.inc;
    set_dwell_i = c.dwell;
    set_mode_i  = c.mode;
    set_legs_i  = c.legs;
  endtask

  task automatic pulse_start();
    @(posedge dac_clk_i); #1 start_i = 1'b1;
    @(posedge dac_clk_i); #1 start_i = 1'b0;
  endtask

  task automatic check_run(input string nm, input cfg_t c, input int max_cyc,
                           output int pts, output int done_at, output logic [SW-1:0] fin);
    obs_t o;
    build_model(c);
    pts = 0;
    done_at = -1;
    fin = step_o;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge dac_clk_i);
      o = '{step_o, point_o, busy_o, done_o};
      if (i < mdl.size()) chk($sformatf("%s cyc%0d", nm, i), 64'(o), 64'(mdl[i]));
      else chk($sformatf("%s overrun cyc%0d done", nm, i), 64'(done_o), 64'd1);
      if (point_o) pts++;
      fin = step_o;
      if (done_o) begin
        done_at = i;
        break;
      end
    end
  endtask

  initial begin
    #(900_000);
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int pts, done_at;
    logic [SW-1:0] fin, held;
    cfg_t c, c2;
    obs_t o;

    vecs[0] = '{'{30'h10000, 30'h50000, 30'h10000, 32'd3, 2'd0, 16'd1}, 5, 20, 30'h50000};
    vecs[1] = '{'{30'h00000, 30'h25000, 30'h10000, 32'd0, 2'd0, 16'd1}, 4, 4, 30'h25000};
    vecs[2] = '{'{30'h30000, 30'h10000, 30'h10000, 32'd1, 2'd2, 16'd3}, 7, 18, 30'h10000};
    vecs[3] = '{'{30'h08000, 30'h08000, 30'h00100, 32'd2, 2'd0, 16'd1}, 1, 3, 30'h08000};
    vecs[4] = '{'{30'h00000, 30'h30000, 30'h10000, 32'd0, 2'd3, 16'd5}, 4, 4, 30'h30000};
    vecs[5] = '{'{30'h00000, 30'h20000, 30'h10000, 32'd0, 2'd1, 16'd2}, 6, 6, 30'h20000};
    vecs[6] = '{'{30'h20000, 30'h05000, 30'h18000, 32'd0, 2'd0, 16'd1}, 3, 3, 30'h05000};
    vecs[7] = '{'{30'h3FFF0000, 30'h3FFFFFFF, 30'h20000000, 32'd0, 2'd0, 16'd1}, 2, 2, 30'h3FFFFFFF};
    vecs[8] = '{'{30'h00000, 30'h10000, 30'h10000, 32'd0, 2'd2, 16'd1}, 2, 2, 30'h10000};

    repeat (3) @(posedge dac_clk_i);
    #1 dac_rst_i = 1'b0;
    @(negedge dac_clk_i);
    chk("reset state", 64'({step_o, point_o, busy_o, done_o}), 64'd0);

    for (int v = 0; v < 9; v++) begin
      set_cfg(vecs[v].c);
      pulse_start();
      check_run($sformatf("vec%0d", v), vecs[v].c, 2000, pts, done_at, fin);
      chk($sformatf("vec%0d points", v), 64'(pts), 64'(vecs[v].exp_pts));
      chk($sformatf("vec%0d done cycle", v), 64'(done_at), 64'(vecs[v].exp_done));
      chk($sformatf("vec%0d final step", v), 64'(fin), 64'(vecs[v].exp_final));
    end

    for (int r = 0; r < 25; r++) begin
      c.start = SW'($urandom_range(0, 32'h100000));
      c.stop  = SW'($urandom_range(0, 32'h100000));
      c.inc   = SW'($urandom_range(32'h8000, 32'h80000));
      c.dwell = 32'($urandom_range(0, 3));
      c.mode  = 2'($urandom_range(0, 3));
      c.legs  = 16'($urandom_range(1, 4));
      set_cfg(c);
      pulse_start();
      check_run($sformatf("rand%0d", r), c, 5000, pts, done_at, fin);
      chk($sformatf("rand%0d points", r), 64'(pts), 64'(mdl_pts));
      chk($sformatf("rand%0d done cycle", r), 64'(done_at), 64'(mdl.size() - 1));
    end

    // Repeat forever, then abort.
    c = '{30'h0, 30'h10000, 30'h10000, 32'd1, 2'd1, 16'd0};
    set_cfg(c);
    pulse_start();
    for (int i = 0; i < 60; i++) begin
      @(negedge dac_clk_i);
      o = '{((i / 2) % 2 == 1) ? SW'(30'h10000) : SW'(0), (i % 2) == 0, 1'b1, 1'b0};
      chk($sformatf("repeat inf cyc%0d", i), 64'({step_o, point_o, busy_o, done_o}), 64'(o));
    end
    @(posedge dac_clk_i); #1 abort_i = 1'b1; held = step_o;
    @(posedge dac_clk_i); #1 abort_i = 1'b0;
    chk("abort busy", 64'(busy_o), 64'd0);
    chk("abort step held", 64'(step_o), 64'(held));
    for (int i = 0; i < 6; i++) begin
      @(negedge dac_clk_i);
      chk($sformatf("after abort cyc%0d", i), 64'({step_o, point_o, busy_o, done_o}),
          64'({held, 1'b0, 1'b0, 1'b0}));
    end

    // Abort and start together from IDLE.
    set_cfg(vecs[0].c);
    @(posedge dac_clk_i); #1 abort_i = 1'b1; start_i = 1'b1; held = step_o;
    @(posedge dac_clk_i); #1 abort_i = 1'b0; start_i = 1'b0;
    @(negedge dac_clk_i);
    chk("abort+start stays idle", 64'({step_o, point_o, busy_o, done_o}),
        64'({held, 1'b0, 1'b0, 1'b0}));

    // Restart while running.
    set_cfg(vecs[0].c);
    pulse_start();
    check_run("pre-restart", vecs[0].c, 7, pts, done_at, fin);
    set_cfg(vecs[2].c);
    pulse_start();
    check_run("restart", vecs[2].c, 2000, pts, done_at, fin);
    chk("restart done cycle", 64'(done_at), 64'd18);

    // Start lands on the final point end: restart wins, no done_o.
    c = '{30'h0, 30'h10000, 30'h10000, 32'd0, 2'd0, 16'd1};
    set_cfg(c);
    pulse_start();
    pulse_start();
    check_run("start at final end", c, 100, pts, done_at, fin);
    chk("start at final end done cycle", 64'(done_at), 64'd2);

    // Reset mid-run.
    set_cfg(vecs[0].c);
    pulse_start();
    repeat (5) @(posedge dac_clk_i);
    #1 dac_rst_i = 1'b1;
    @(posedge dac_clk_i); #1 dac_rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge dac_clk_i);
      chk($sformatf("reset mid-run cyc%0d", i), 64'({step_o, point_o, busy_o, done_o}), 64'd0);
    end

    // Stop word rewritten while running takes effect only on the next start.
    c = '{30'h0, 30'h40000, 30'h10000, 32'd0, 2'd0, 16'd1};
    set_cfg(c);
    pulse_start();
    set_stop_i = 30'h20000;
    check_run("cfg old stop", c, 100, pts, done_at, fin);
    chk("cfg old stop final", 64'(fin), 64'h40000);
    c2 = c;
    c2.stop = 30'h20000;
    pulse_start();
    check_run("cfg new stop", c2, 100, pts, done_at, fin);
    chk("cfg new stop final", 64'(fin), 64'h20000);
    chk("cfg new stop done cycle", 64'(done_at), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
